// File: rtl/reg_file.sv
// Two-read, one-write register file with hardwired-zero entry 0 and a committed-write counter.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_RegWrite,
  input  logic [ADDR_WIDTH-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic [31:0]           wr_count
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [31:0]           wr_count_q;
  logic [31:0]           wr_count_d;
  logic                  commit;

  // A write commits only when enabled and aimed at a non-zero index.
  assign commit = wb_RegWrite && (wb_reg != '0);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (commit) begin
      regs_d[wb_reg] = wb_data;
      wr_count_d     = wr_count_q + 32'd1;
    end
    regs_d[0] = '0;
  end

  // Reset wins over a simultaneous write, which is dropped and not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic bypass_rs;
  logic bypass_rt;

  // Forwarding never applies during reset; index 0 is excluded through commit.
  assign bypass_rs = commit && !reset && (rs_addr == wb_reg);
  assign bypass_rt = commit && !reset && (rt_addr == wb_reg);

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) begin
      rs_data = bypass_rs ? wb_data : regs_q[rs_addr];
    end
    if (rt_addr != '0) begin
      rt_data = bypass_rt ? wb_data : regs_q[rt_addr];
    end
  end
`else
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) begin
      rs_data = regs_q[rs_addr];
    end
    if (rt_addr != '0) begin
      rt_data = regs_q[rt_addr];
    end
  end
`endif

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations are hand-computed per scenario.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        wb_RegWrite;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wr_count;

  int n_vec = 0;
  int n_err = 0;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_RegWrite(wb_RegWrite),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .wr_count   (wr_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wb_RegWrite = 1'b1;
    wb_reg      = a;
    wb_data     = d;
    step();
    wb_RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      n_vec++;
      if (rs_data !== 32'h0) begin
        n_err++;
        $display("FAIL reset_rs[%0d]: got %h, required %h", i, rs_data, 32'h0);
      end
      n_vec++;
      if (rt_data !== 32'h0) begin
        n_err++;
        $display("FAIL reset_rt[%0d]: got %h, required %h", 31 - i, rt_data, 32'h0);
      end
    end
    n_vec++;
    if (wr_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d, required 0", wr_count);
    end
  endtask

  task automatic test_basic_write();
    do_write(5'd5, 32'hDEAD_BEEF);
    rs_addr = 5'd5;
    rt_addr = 5'd5;
    #1;
    n_vec++;
    if (rs_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL basic_rs: got %h, required %h", rs_data, 32'hDEAD_BEEF);
    end
    n_vec++;
    if (rt_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL basic_rt: got %h, required %h", rt_data, 32'hDEAD_BEEF);
    end
    n_vec++;
    if (wr_count !== 32'd1) begin
      n_err++;
      $display("FAIL basic_count: got %0d, required 1", wr_count);
    end
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'h1234_5678);
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    #1;
    n_vec++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      n_err++;
      $display("FAIL zero_read: got rs=%h rt=%h, required 0", rs_data, rt_data);
    end
    n_vec++;
    if (wr_count !== 32'd1) begin
      n_err++;
      $display("FAIL zero_count: got %0d, required 1", wr_count);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rs;
    do_write(5'd9, 32'h0000_0001);
    do_write(5'd3, 32'h0000_0033);
    // count is now 3
    wb_RegWrite = 1'b1;
    wb_reg      = 5'd9;
    wb_data     = 32'hA5A5_A5A5;
    rs_addr     = 5'd9;
    rt_addr     = 5'd5;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_rs = 32'hA5A5_A5A5;
`else
    exp_rs = 32'h0000_0001;
`endif
    n_vec++;
    if (rs_data !== exp_rs) begin
      n_err++;
      $display("FAIL bypass_same_cycle: got %h, required %h", rs_data, exp_rs);
    end
    n_vec++;
    if (rt_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL bypass_other_port: got %h, required %h", rt_data, 32'hDEAD_BEEF);
    end
    step();
    wb_RegWrite = 1'b0;
    n_vec++;
    if (rs_data !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL bypass_after_edge: got %h, required %h", rs_data, 32'hA5A5_A5A5);
    end
    // A write to index 0 must never be forwarded.
    wb_RegWrite = 1'b1;
    wb_reg      = 5'd0;
    wb_data     = 32'hFFFF_FFFF;
    rs_addr     = 5'd0;
    rt_addr     = 5'd0;
    #1;
    n_vec++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      n_err++;
      $display("FAIL bypass_zero: got rs=%h rt=%h, required 0", rs_data, rt_data);
    end
    step();
    wb_RegWrite = 1'b0;
    n_vec++;
    if (wr_count !== 32'd4) begin
      n_err++;
      $display("FAIL bypass_count: got %0d, required 4", wr_count);
    end
  endtask

  task automatic test_reset_vs_write();
    reset       = 1'b1;
    wb_RegWrite = 1'b1;
    wb_reg      = 5'd3;
    wb_data     = 32'h0000_FFFF;
    rs_addr     = 5'd3;
    rt_addr     = 5'd5;
    #1;
    n_vec++;
    if (rs_data !== 32'h0000_0033) begin
      n_err++;
      $display("FAIL rst_no_bypass: got %h, required %h", rs_data, 32'h33);
    end
    step();
    reset       = 1'b0;
    wb_RegWrite = 1'b0;
    #1;
    n_vec++;
    if (rs_data !== 32'h0) begin
      n_err++;
      $display("FAIL rst_write_dropped: got %h, required 0", rs_data);
    end
    n_vec++;
    if (rt_data !== 32'h0) begin
      n_err++;
      $display("FAIL rst_clears_reg5: got %h, required 0", rt_data);
    end
    n_vec++;
    if (wr_count !== 32'd0) begin
      n_err++;
      $display("FAIL rst_count: got %0d, required 0", wr_count);
    end
  endtask

  task automatic test_same_value();
    do_write(5'd7, 32'h77);
    do_write(5'd7, 32'h77);
    rs_addr = 5'd7;
    #1;
    n_vec++;
    if (wr_count !== 32'd2) begin
      n_err++;
      $display("FAIL same_value_count: got %0d, required 2", wr_count);
    end
    n_vec++;
    if (rs_data !== 32'h77) begin
      n_err++;
      $display("FAIL same_value_data: got %h, required %h", rs_data, 32'h77);
    end
  endtask

  task automatic test_write_disabled();
    wb_RegWrite = 1'b0;
    wb_reg      = 5'd7;
    wb_data     = 32'h0BAD;
    step();
    rs_addr = 5'd7;
    #1;
    n_vec++;
    if (rs_data !== 32'h77) begin
      n_err++;
      $display("FAIL disabled_data: got %h, required %h", rs_data, 32'h77);
    end
    n_vec++;
    if (wr_count !== 32'd2) begin
      n_err++;
      $display("FAIL disabled_count: got %0d, required 2", wr_count);
    end
  endtask

  task automatic test_back_to_back();
    do_write(5'd1, 32'h1111_0001);
    do_write(5'd2, 32'h2222_0002);
    do_write(5'd31, 32'hFFFF_001F);
    rs_addr = 5'd1;
    rt_addr = 5'd31;
    #1;
    n_vec++;
    if (rs_data !== 32'h1111_0001 || rt_data !== 32'hFFFF_001F) begin
      n_err++;
      $display("FAIL b2b_1_31: got rs=%h rt=%h, required 11110001 ffff001f", rs_data, rt_data);
    end
    rs_addr = 5'd2;
    rt_addr = 5'd2;
    #1;
    n_vec++;
    if (rs_data !== 32'h2222_0002 || rt_data !== 32'h2222_0002) begin
      n_err++;
      $display("FAIL b2b_2: got rs=%h rt=%h, required 22220002", rs_data, rt_data);
    end
    n_vec++;
    if (wr_count !== 32'd5) begin
      n_err++;
      $display("FAIL b2b_count: got %0d, required 5", wr_count);
    end
  endtask

  task automatic test_counter_wrap();
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count_q;
    #1;
    n_vec++;
    if (wr_count !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_preload: got %h, required ffffffff", wr_count);
    end
    do_write(5'd10, 32'h00C0_FFEE);
    rs_addr = 5'd10;
    #1;
    n_vec++;
    if (wr_count !== 32'd0) begin
      n_err++;
      $display("FAIL wrap_count: got %h, required 0", wr_count);
    end
    n_vec++;
    if (rs_data !== 32'h00C0_FFEE) begin
      n_err++;
      $display("FAIL wrap_data: got %h, required %h", rs_data, 32'h00C0_FFEE);
    end
  endtask

  initial begin
    reset       = 1'b1;
    wb_RegWrite = 1'b0;
    wb_reg      = '0;
    wb_data     = '0;
    rs_addr     = '0;
    rt_addr     = '0;
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_bypass();
    test_reset_vs_write();
    test_same_value();
    test_write_disabled();
    test_back_to_back();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the register and data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving the register index width (2^ADDR_WIDTH entries).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wb_RegWrite, input, 1 bit: write enable from the write-back stage.
REQ-006 The block SHALL have port wb_reg, input, ADDR_WIDTH bits: destination register index from the write-back stage.
REQ-007 The block SHALL have port wb_data, input, DATA_WIDTH bits: write data from the write-back stage.
REQ-008 The block SHALL have port rs_addr, input, ADDR_WIDTH bits: read port A index for the decode stage.
REQ-009 The block SHALL have port rt_addr, input, ADDR_WIDTH bits: read port B index for the decode stage.
REQ-010 The block SHALL have port rs_data, output, DATA_WIDTH bits: read port A data.
REQ-011 The block SHALL have port rt_data, output, DATA_WIDTH bits: read port B data.
REQ-012 The block SHALL have port wr_count, output, 32 bits: count of committed writes to non-zero registers.

Function
REQ-013 Storage SHALL be 2^ADDR_WIDTH registers of DATA_WIDTH bits; register 0 is hardwired to zero.
REQ-014 On a rising clk edge with reset low, wb_RegWrite high and wb_reg != 0, entry wb_reg SHALL take wb_data.
REQ-015 A write with wb_reg == 0 SHALL be discarded: entry 0 is unchanged and wr_count is not incremented.
REQ-016 Writes with wb_RegWrite low SHALL leave all state unchanged.
REQ-017 rs_data and rt_data SHALL be combinational functions of the address inputs and the stored contents, with zero-cycle latency.
REQ-018 Reads of index 0 SHALL return 0 on either port, regardless of any write.
REQ-019 Both ports SHALL be able to read the same index in the same cycle and return identical data.
REQ-020 wr_count SHALL increment by 1 on each committed write per REQ-014, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 A write to a register holding an identical value SHALL still count as a committed write.

Reset
REQ-022 When reset is high at a rising clk edge, all entries SHALL become 0 and wr_count SHALL become 0 on that edge.
REQ-023 Reset SHALL take priority over a simultaneous write; the write is dropped and not counted.
REQ-024 While reset is high, rs_data and rt_data SHALL reflect stored contents, which are all 0 after the first reset edge.
REQ-025 Reset asserted during normal operation SHALL clear state in the same way as reset at power-up, with no residual write effects.

Configuration
REQ-026 Macro REG_FILE_BYPASS_EN SHALL select write-to-read bypass behaviour.
REQ-027 With REG_FILE_BYPASS_EN defined, when wb_RegWrite is high, wb_reg != 0, reset is low and a read address equals wb_reg, that port SHALL return wb_data in the same cycle.
REQ-028 With REG_FILE_BYPASS_EN undefined, reads SHALL return the stored value only, and a same-cycle write SHALL become visible the cycle after the edge.
REQ-029 Bypass SHALL never apply to index 0 or while reset is high.

Verification
REQ-030 Reset scenario: assert reset for 1 edge, then read all 32 indices on both ports -> every read returns 0 and wr_count == 0.
REQ-031 Basic write scenario: write 0xDEADBEEF to reg 5, then read rs_addr = 5 and rt_addr = 5 -> both ports return 0xDEADBEEF and wr_count == 1.
REQ-032 Zero-register scenario: write 0x12345678 to reg 0 -> reads of reg 0 return 0 and wr_count is unchanged.
REQ-033 Bypass scenario: in the same cycle, write 0xA5A5A5A5 to reg 9 and set rs_addr = 9 while reg 9 holds 0x1 -> rs_data is 0xA5A5A5A5 with the macro defined and 0x1 without it; after the edge, rs_data is 0xA5A5A5A5 in both builds.
REQ-034 Reset-vs-write scenario: assert reset together with a write of 0xFFFF to reg 3 -> after the edge, reg 3 reads 0 and wr_count == 0.
REQ-035 Counter-wrap scenario: force or preload wr_count to 0xFFFFFFFF, then commit one write -> wr_count == 0.
